// File: rtl/decimal_display_driver.sv
// -----------------------------------------------------------------------------
// decimal_display_driver
//
// Purpose:
//   Shows a 16-bit unsigned binary value as a decimal number on an 8-digit,
//   active-low, multiplexed 7-segment display.
//
//   A sequential shift-add-3 (double-dabble) engine converts the value to five
//   BCD digits. The result reaches the display register only after all 16
//   shifts, so a half-converted number is never shown. A free-running scanner
//   drives one digit at a time and can blank leading zeros.
//
// Parameters:
//   CLK_FREQ      - system clock frequency in Hz
//   DIGIT_HZ      - digit-advance rate; each digit is lit for
//                   CLK_FREQ/DIGIT_HZ cycles (must be >= 1)
//   BLANK_LEADING - 1: blank leading zeros, 0: always show five digits
//
// Ports:
//   clk       in   1  system clock; all state changes on its rising edge
//   rst       in   1  synchronous, active-high reset
//   value     in  16  unsigned binary value to display
//   SEG       out  8  cathodes, active-low; bit0 = a .. bit6 = g, bit7 = DP
//   AN        out  8  anodes, active-low, one-hot; bit0 = rightmost digit
//   conv_busy out  1  high while the converter is shifting (16 cycles)
// -----------------------------------------------------------------------------
module decimal_display_driver #(
    parameter int CLK_FREQ      = 100000000,
    parameter int DIGIT_HZ      = 1000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    output logic [7:0]  SEG,
    output logic [7:0]  AN,
    output logic        conv_busy
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int DWELL = CLK_FREQ / DIGIT_HZ;
    // A one-cycle dwell still needs a one-bit counter so the widths stay legal.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
    function automatic logic [19:0] bcd_adjust(input logic [19:0] bcd);
        logic [19:0] res;
        res = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

    // Active-low 7-segment pattern with the decimal point off.
    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] pat;
        case (digit)
            4'd0:    pat = 8'hC0;
            4'd1:    pat = 8'hF9;
            4'd2:    pat = 8'hA4;
            4'd3:    pat = 8'hB0;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h92;
            4'd6:    pat = 8'h82;
            4'd7:    pat = 8'hF8;
            4'd8:    pat = 8'h80;
            4'd9:    pat = 8'h90;
            default: pat = 8'hFF;
        endcase
        return pat;
    endfunction

    // Active-low one-hot anode pattern. The three unused digits stay dark.
    function automatic logic [7:0] an_decode(input logic [2:0] idx);
        logic [7:0] pat;
        case (idx)
            3'd0:    pat = 8'hFE;
            3'd1:    pat = 8'hFD;
            3'd2:    pat = 8'hFB;
            3'd3:    pat = 8'hF7;
            3'd4:    pat = 8'hEF;
            default: pat = 8'hFF;
        endcase
        return pat;
    endfunction

    // -------------------------------------------------------------------------
    // Converter state
    // -------------------------------------------------------------------------
    conv_state_t  state_r;
    logic [15:0]  shreg_r;       // binary bits still to be shifted in
    logic [19:0]  bcd_r;         // BCD accumulator being built
    logic [3:0]   iter_r;        // shifts completed so far
    logic [15:0]  cap_r;         // value captured for the running conversion
    logic [15:0]  last_value_r;  // value behind the current display contents
    logic         pending_r;     // forces a conversion even if value is unchanged
    logic         busy_r;
    logic [19:0]  disp_r;        // committed BCD digits the scanner reads
    logic [19:0]  adj_s;

    // Nibble correction applied to the accumulator before each shift.
    always_comb begin
        adj_s = bcd_adjust(bcd_r);
    end

    // Double-dabble converter FSM: IDLE -> SHIFT (16 cycles) -> COMMIT -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            shreg_r      <= 16'd0;
            bcd_r        <= 20'd0;
            iter_r       <= 4'd0;
            cap_r        <= 16'd0;
            last_value_r <= 16'd0;
            pending_r    <= 1'b1;
            busy_r       <= 1'b0;
            disp_r       <= 20'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pending_r || (value != last_value_r)) begin
                        shreg_r   <= value;
                        cap_r     <= value;
                        bcd_r     <= 20'd0;
                        iter_r    <= 4'd0;
                        pending_r <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_SHIFT;
                    end else begin
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    // Adjusted accumulator and remaining binary bits move
                    // left together as one 36-bit register.
                    {bcd_r, shreg_r} <= {adj_s, shreg_r} << 1;
                    iter_r           <= iter_r + 4'd1;
                    if (iter_r == 4'd15) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_COMMIT;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end
                end
                ST_COMMIT: begin
                    // All five digits change in the same cycle.
                    disp_r       <= bcd_r;
                    last_value_r <= cap_r;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign conv_busy = busy_r;

    // -------------------------------------------------------------------------
    // Scanner
    // -------------------------------------------------------------------------
    logic [CW-1:0] dwell_r;
    logic [2:0]    idx_r;
    logic [3:0]    digit_s;
    logic          blank_s;
    logic [7:0]    seg_s;
    logic [7:0]    seg_r;
    logic [7:0]    an_r;

    // Select the digit under the scan index and decide whether it is a leading zero.
    always_comb begin
        digit_s = 4'd0;
        blank_s = 1'b0;
        case (idx_r)
            3'd0: begin
                digit_s = disp_r[3:0];
                blank_s = 1'b0;   // the units digit is always shown
            end
            3'd1: begin
                digit_s = disp_r[7:4];
                blank_s = (disp_r[19:4] == 16'd0);
            end
            3'd2: begin
                digit_s = disp_r[11:8];
                blank_s = (disp_r[19:8] == 12'd0);
            end
            3'd3: begin
                digit_s = disp_r[15:12];
                blank_s = (disp_r[19:12] == 8'd0);
            end
            3'd4: begin
                digit_s = disp_r[19:16];
                blank_s = (disp_r[19:16] == 4'd0);
            end
            default: begin
                digit_s = 4'd0;
                blank_s = 1'b1;
            end
        endcase
    end

    // Cathode pattern for the digit currently selected.
    always_comb begin
        if ((BLANK_LEADING != 0) && blank_s) begin
            seg_s = 8'hFF;
        end else begin
            seg_s = seg_encode(digit_s);
        end
    end

    // Dwell counter, digit index and registered anode/cathode drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_r <= '0;
            idx_r   <= 3'd0;
            an_r    <= 8'hFF;
            seg_r   <= 8'hFF;
        end else begin
            if (dwell_r == DWELL_LAST) begin
                dwell_r <= '0;
                idx_r   <= (idx_r == 3'd4) ? 3'd0 : (idx_r + 3'd1);
            end else begin
                dwell_r <= dwell_r + CW'(1);
                idx_r   <= idx_r;
            end
            an_r  <= an_decode(idx_r);
            seg_r <= seg_s;
        end
    end

    assign AN  = an_r;
    assign SEG = seg_r;

endmodule

// File: tb/tb_decimal_display_driver.sv
// -----------------------------------------------------------------------------
// tb_decimal_display_driver
//
// Self-checking bench for decimal_display_driver with a dwell of 4 cycles.
// Two instances share the same inputs: one blanks leading zeros and one
// shows all five digits. Expected anode/cathode patterns come from decimal
// arithmetic on the displayed number. Expected timing follows the converter's
// externally visible rule: conv_busy is high for 16 cycles after value is
// sampled, and the new number is driven 18 cycles after that sample.
// -----------------------------------------------------------------------------
module tb_decimal_display_driver;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [7:0]  seg_b, an_b, seg_n, an_n;
    logic        busy_b, busy_n;

    int tests_run    = 0;
    int tests_failed = 0;
    int ecount       = 0;   // rising edges since reset was last sampled high
    int shown_v      = 0;   // number the display is expected to show

    logic [7:0] enc_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    decimal_display_driver #(.CLK_FREQ(4), .DIGIT_HZ(1), .BLANK_LEADING(1)) dut (
        .clk(clk), .rst(rst), .value(value),
        .SEG(seg_b), .AN(an_b), .conv_busy(busy_b)
    );

    decimal_display_driver #(.CLK_FREQ(4), .DIGIT_HZ(1), .BLANK_LEADING(0)) dut_nb (
        .clk(clk), .rst(rst), .value(value),
        .SEG(seg_n), .AN(an_n), .conv_busy(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    // Expected cathodes for decimal position idx of number v.
    function automatic logic [7:0] exp_seg(input int v, input int idx, input bit blank);
        int p;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (blank && idx >= 1 && v < p) return 8'hFF;
        return enc_tab[(v / p) % 10];
    endfunction

    function automatic logic [7:0] exp_an(input int idx);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << idx);
    endfunction

    // Runs n cycles after value is (optionally) driven, checking every cycle.
    // old_v: number shown before; new_v: number sampled at the first edge;
    // change_at >= 0: value switches to second_v after that cycle's check.
    task automatic timed_check(input string name, input int old_v, input int new_v,
                               input bit drive_new, input int second_v, input int change_at,
                               input bit force_conv, input int n);
        bit conv1, conv2, exp_busy;
        int idx, disp_v;
        conv1 = force_conv || (new_v != old_v);
        conv2 = (change_at >= 0) && (second_v != new_v);
        if (drive_new) value = 16'(new_v);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            idx    = ((ecount - 1) / 4) % 5;
            disp_v = (conv1 && k >= 18) ? new_v : old_v;
            if (conv2 && k >= 36) disp_v = second_v;
            exp_busy = (conv1 && k < 16) || (conv2 && k >= 18 && k < 34);
            tests_run++;
            if (an_b !== exp_an(idx) || an_n !== exp_an(idx)) begin
                tests_failed++;
                $display("FAIL %s an k=%0d: got %h/%h want %h", name, k, an_b, an_n, exp_an(idx));
            end
            tests_run++;
            if (seg_b !== exp_seg(disp_v, idx, 1'b1)) begin
                tests_failed++;
                $display("FAIL %s seg_blank k=%0d idx=%0d: got %h want %h (value %0d)",
                         name, k, idx, seg_b, exp_seg(disp_v, idx, 1'b1), disp_v);
            end
            tests_run++;
            if (seg_n !== exp_seg(disp_v, idx, 1'b0)) begin
                tests_failed++;
                $display("FAIL %s seg_full k=%0d idx=%0d: got %h want %h (value %0d)",
                         name, k, idx, seg_n, exp_seg(disp_v, idx, 1'b0), disp_v);
            end
            tests_run++;
            if (busy_b !== exp_busy || busy_n !== exp_busy) begin
                tests_failed++;
                $display("FAIL %s conv_busy k=%0d: got %b/%b want %b", name, k, busy_b, busy_n, exp_busy);
            end
            if (k == change_at) value = 16'(second_v);
        end
        shown_v = conv2 ? second_v : (conv1 ? new_v : old_v);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        value = 16'd0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (an_b !== 8'hFF || seg_b !== 8'hFF || an_n !== 8'hFF || seg_n !== 8'hFF ||
                busy_b !== 1'b0 || busy_n !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs k=%0d: got an=%h seg=%h busy=%b want FF/FF/0",
                         k, an_b, seg_b, busy_b);
            end
        end
        rst = 1'b0;
        // Reset leaves a pending conversion even though value matches.
        timed_check("post_reset", 0, 0, 1'b0, 0, -1, 1'b1, 40);
    endtask

    task automatic test_values();
        timed_check("v12345", shown_v, 12345, 1'b1, 0, -1, 1'b0, 40);
        timed_check("v65535", shown_v, 65535, 1'b1, 0, -1, 1'b0, 40);
        timed_check("v100",   shown_v, 100,   1'b1, 0, -1, 1'b0, 40);
    endtask

    task automatic test_change_during_shift();
        // 7 is sampled; 9 arrives during the 5th shift and must wait its turn.
        timed_check("seq7_9", shown_v, 7, 1'b1, 9, 4, 1'b0, 46);
    endtask

    task automatic test_reset_mid();
        int idx;
        value = 16'd4321;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            idx = ((ecount - 1) / 4) % 5;
            tests_run++;
            if (seg_b !== exp_seg(shown_v, idx, 1'b1) || busy_b !== 1'b1) begin
                tests_failed++;
                $display("FAIL rst_mid_pre k=%0d: got seg=%h busy=%b want %h/1",
                         k, seg_b, busy_b, exp_seg(shown_v, idx, 1'b1));
            end
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (busy_b !== 1'b0 || an_b !== 8'hFF || seg_b !== 8'hFF) begin
            tests_failed++;
            $display("FAIL rst_mid_hit: got busy=%b an=%h seg=%h want 0/FF/FF", busy_b, an_b, seg_b);
        end
        rst = 1'b0;
        timed_check("rst_mid_reconv", 0, 4321, 1'b0, 0, -1, 1'b1, 40);
    endtask

    task automatic test_random();
        int nv;
        for (int r = 0; r < 5; r++) begin
            nv = int'($urandom_range(0, 65535));
            timed_check("random", shown_v, nv, 1'b1, 0, -1, 1'b0, 40);
        end
    endtask

    task automatic test_zero();
        timed_check("zero", shown_v, 0, 1'b1, 0, -1, 1'b0, 40);
        timed_check("same_value", shown_v, 0, 1'b1, 0, -1, 1'b0, 24);
    endtask

    initial begin
        test_reset();
        test_values();
        test_change_during_shift();
        test_reset_mid();
        test_random();
        test_zero();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
